// File: rtl/serial_frame_receiver_pkg.sv
// Shared types and line levels for the serial frame receiver.
// The parity state is only reachable when RX_PARITY_EN is defined.
package serial_frame_receiver_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial input, consumer handshake and status pulses of the serial frame receiver.
// Carries parity_err only when RX_PARITY_EN is defined.
interface serial_frame_receiver_if
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);
  logic              rxd;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overflow;
`ifdef RX_PARITY_EN
  logic              parity_err;
`endif

  // Receiver side.
  modport master (
    input  rxd,
    input  out_ready,
    output out_data,
    output out_valid,
    output frame_err,
`ifdef RX_PARITY_EN
    output parity_err,
`endif
    output overflow
  );

  // Line driver and byte consumer side.
  modport slave (
    output rxd,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  frame_err,
`ifdef RX_PARITY_EN
    input  parity_err,
`endif
    input  overflow
  );

endinterface

// File: rtl/serial_frame_receiver_byte_fifo.sv
// Small synchronous byte FIFO with wrap-bit pointers; accepts a push while full
// only when a pop happens on the same edge.
module byte_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [AW:0]       wr_q, rd_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    // Gated so the head reads as zero whenever nothing is buffered.
    head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Samples rxd once per clock, rebuilds start/data/stop frames into bytes and buffers them.
// Define RX_PARITY_EN for an even-parity bit before the stop bit and the parity_err pulse.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  serial_frame_receiver_if.master bus
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              frame_err_q;
  logic              overflow_q;
`ifdef RX_PARITY_EN
  logic              par_q;
  logic              parity_err_q;
`endif

  logic              stop_ok;
  logic              byte_good;
  logic              pop;
  logic              empty;
  logic              full;
  logic [DATA_W-1:0] head;

  always_comb begin
    stop_ok   = (state_q == StStop) && (bus.rxd == STOP_LVL);
`ifdef RX_PARITY_EN
    byte_good = stop_ok && (par_q == ^shift_q);
`else
    byte_good = stop_ok;
`endif
    pop       = !empty && bus.out_ready;
  end

  byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (byte_good),
    .push_data  (shift_q),
    .pop        (pop),
    .head       (head),
    .empty      (empty),
    .full       (full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.rxd == START_LVL) begin
            state_q <= StData;
            cnt_q   <= '0;
          end
        end
        StData: begin
          shift_q[cnt_q] <= bus.rxd;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
`ifdef RX_PARITY_EN
            state_q <= StParity;
`else
            state_q <= StStop;
`endif
          end
        end
`ifdef RX_PARITY_EN
        StParity: begin
          par_q   <= bus.rxd;
          state_q <= StStop;
        end
`endif
        StStop: begin
          // A 1 here is a framing error, never a fresh start bit.
          state_q <= StIdle;
          if (!stop_ok) begin
            frame_err_q <= 1'b1;
`ifdef RX_PARITY_EN
          end else if (!byte_good) begin
            parity_err_q <= 1'b1;
`endif
          end else if (full && !pop) begin
            overflow_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_data   = head;
  assign bus.out_valid  = !empty;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;
`ifdef RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomized self-checking bench for serial_frame_receiver against a queue-based model.
// Exercises the parity path as well when RX_PARITY_EN is defined.
module tb_serial_frame_receiver;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;

  serial_frame_receiver_if #(.DATA_W(DW)) bus ();

  serial_frame_receiver #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: bytes the consumer should still see, and pulses expected after the last edge.
  logic [DW-1:0] model_q[$];
  logic          exp_fe;
  logic          exp_ov;
  logic          exp_pe;
  int            ready_mode;  // 0 low, 1 high, 2 toggle, 3 random

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) check_eq("out_data", 32'(bus.out_data), 32'(model_q[0]));
    check_eq("frame_err", 32'(bus.frame_err), 32'(exp_fe));
    check_eq("overflow", 32'(bus.overflow), 32'(exp_ov));
`ifdef RX_PARITY_EN
    check_eq("parity_err", 32'(bus.parity_err), 32'(exp_pe));
`endif
  endtask

  // Drives one line sample, advances the model across the edge, then checks.
  task automatic tick(input logic b, input bit is_stop, input logic [DW-1:0] d,
                      input bit par_bad);
    bit popped;
    bus.rxd = b;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      2:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    popped = bus.out_ready && (model_q.size() > 0);
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    exp_pe = 1'b0;
    if (popped) void'(model_q.pop_front());
    if (is_stop) begin
      if (b)                           exp_fe = 1'b1;
      else if (par_bad)                exp_pe = 1'b1;
      else if (model_q.size() < DEPTH) model_q.push_back(d);
      else                             exp_ov = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input bit par_flip);
    bit par_bad;
    par_bad = 1'b0;
    tick(1'b1, 1'b0, d, 1'b0);
    for (int i = 0; i < DW; i++) tick(d[i], 1'b0, d, 1'b0);
`ifdef RX_PARITY_EN
    par_bad = par_flip;
    tick((^d) ^ par_flip, 1'b0, d, 1'b0);
`endif
    tick(stop_bit, 1'b1, d, par_bad);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] b_c3;
    logic [DW-1:0] rnd;
    bus.rxd       = 1'b0;
    bus.out_ready = 1'b0;
    exp_fe        = 1'b0;
    exp_ov        = 1'b0;
    exp_pe        = 1'b0;
    ready_mode    = 1;
    rst           = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_outputs();
    check_eq("reset_data", 32'(bus.out_data), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single good frame, then a framing error followed by a clean frame.
    ready_mode = 1;
    send_frame(8'hA5, 1'b0, 1'b0);
    gap(2);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    gap(2);

    // Fill the FIFO with no consumer; the fifth frame overflows.
    ready_mode = 0;
    for (int i = 1; i <= 5; i++) send_frame(DW'(i), 1'b0, 1'b0);
    ready_mode = 1;
    gap(6);

    // Reset in the middle of a frame.
    b_c3 = 8'hC3;
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) tick(b_c3[i], 1'b0, '0, 1'b0);
    rst = 1'b0;
    model_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    exp_pe = 1'b0;
    #1;
    check_outputs();
    check_eq("rst_mid_data", 32'(bus.out_data), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.rxd = 1'b0;
    send_frame(8'h7E, 1'b0, 1'b0);
    gap(2);

    // Back-to-back extremes with a toggling consumer.
    ready_mode = 2;
    send_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    gap(4);

`ifdef RX_PARITY_EN
    ready_mode = 1;
    send_frame(8'h01, 1'b0, 1'b1);
    gap(2);
    send_frame(8'h01, 1'b0, 1'b0);
    gap(2);
    // Stop error wins over a bad parity bit.
    send_frame(8'h01, 1'b1, 1'b1);
    gap(2);
`endif

    // Random frames, gaps, errors and consumer behaviour.
    ready_mode = 3;
    for (int f = 0; f < 60; f++) begin
      rnd = DW'($urandom);
      send_frame(rnd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      gap($urandom_range(0, 3));
    end
    ready_mode = 1;
    gap(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
